// File: rtl/ysyx_25030081_lsu.sv
// Load/store unit that turns one core memory request into a valid/ready bus request.
// It handles byte-lane steering, load extension, alignment and legality errors, and a response timeout.
module ysyx_25030081_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  output logic        req_wen,
  output logic [3:0]  req_wmask,
  output logic [31:0] req_wdata,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        store_q, store_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;

  logic        legal_load, legal_store, op_ok, misaligned;
  logic [16:0] cnt_inc;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [3:0]  wmask;
  logic [31:0] wdata_lanes;

  // Decode of the incoming request; only consulted in IDLE.
  assign legal_load  = !(mem_op == 3'b011 || mem_op[2:1] == 2'b11);
  assign legal_store = !mem_op[2] && (mem_op[1:0] != 2'b11);
  assign op_ok       = (mem_ren && !mem_wen && legal_load) || (mem_wen && !mem_ren && legal_store);
  assign misaligned  = (mem_op[1:0] == 2'b01 && addr[0]) || (mem_op[1:0] == 2'b10 && addr[1:0] != 2'b00);

  assign cnt_inc = {1'b0, cnt_q} + 17'd1;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    ld_byte = 8'h00;
    ld_half = addr_q[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];
    ld_ext  = rsp_rdata;
    case (addr_q[1:0])
      2'd0:    ld_byte = rsp_rdata[7:0];
      2'd1:    ld_byte = rsp_rdata[15:8];
      2'd2:    ld_byte = rsp_rdata[23:16];
      default: ld_byte = rsp_rdata[31:24];
    endcase
    case (op_q[1:0])
      2'b00:   ld_ext = {{24{~op_q[2] & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{~op_q[2] & ld_half[15]}}, ld_half};
      default: ld_ext = rsp_rdata;
    endcase
  end

  always_comb begin
    wmask       = 4'b1111;
    wdata_lanes = wdata_q;
    case (op_q[1:0])
      2'b00: begin
        wmask       = 4'b0001 << addr_q[1:0];
        wdata_lanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wmask       = 4'b0011 << addr_q[1:0];
        wdata_lanes = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    store_d = store_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_ren || mem_wen) begin
          op_d    = mem_op;
          addr_d  = addr;
          wdata_d = wdata;
          store_d = mem_wen;
          rdata_d = 32'h0;
          cnt_d   = 16'h0;
          if (!op_ok || misaligned) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (req_ready) begin
          cnt_d   = 16'h0;
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (rsp_valid) begin
          err_d   = 1'b0;
          rdata_d = store_q ? 32'h0 : ld_ext;
          state_d = DONE;
        end else if (cnt_inc == 17'(TIMEOUT)) begin
          err_d   = 1'b1;
          rdata_d = 32'h0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_inc[15:0];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      store_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 16'h0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      store_q <= store_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are gated by state, so everything reads zero outside the phase where it is meaningful.
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = done && err_q;
  assign rdata     = done ? rdata_q : 32'h0;
  assign req_valid = (state_q == REQ);
  assign req_addr  = req_valid ? {addr_q[31:2], 2'b00} : 32'h0;
  assign req_wen   = req_valid && store_q;
  assign req_wmask = req_wen ? wmask : 4'b0000;
  assign req_wdata = req_wen ? wdata_lanes : 32'h0;

endmodule

// File: tb/tb_ysyx_25030081_lsu.sv
// Directed self-checking bench for ysyx_25030081_lsu (TIMEOUT=4).
// Inputs are driven 1 ns after the rising edge and outputs are sampled at that point.
module tb_ysyx_25030081_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_ren, mem_wen;
  logic [2:0]  mem_op;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        done, err, busy;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [3:0]  req_wmask;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  int total = 0;
  int bad   = 0;

  ysyx_25030081_lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_op(mem_op),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err), .busy(busy),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wen(req_wen),
    .req_wmask(req_wmask), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
  );

  always #5 clk = ~clk;

  // Load vectors: op, address, bus word, expected result, expected word address.
  localparam logic [2:0]  LD_OP   [6] = '{3'b000, 3'b101, 3'b001, 3'b100, 3'b010, 3'b001};
  localparam logic [31:0] LD_ADDR [6] = '{32'h80000003, 32'h80000002, 32'h80000002,
                                          32'h80000002, 32'h80000004, 32'h80000000};
  localparam logic [31:0] LD_RSP  [6] = '{32'h80FF1234, 32'h8001ABCD, 32'h8001ABCD,
                                          32'h80FF1234, 32'hDEADBEEF, 32'h8001ABCD};
  localparam logic [31:0] LD_EXP  [6] = '{32'hFFFFFF80, 32'h00008001, 32'hFFFF8001,
                                          32'h000000FF, 32'hDEADBEEF, 32'hFFFFABCD};
  localparam logic [31:0] LD_WA   [6] = '{32'h80000000, 32'h80000000, 32'h80000000,
                                          32'h80000000, 32'h80000004, 32'h80000000};

  // Error vectors: ren, wen, op, address.
  localparam logic        ER_REN  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam logic        ER_WEN  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [2:0]  ER_OP   [5] = '{3'b010, 3'b011, 3'b010, 3'b100, 3'b001};
  localparam logic [31:0] ER_ADDR [5] = '{32'h80000002, 32'h80000000, 32'h80000000,
                                          32'h80000000, 32'h80000001};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one cycle (cycle N); returns 1 ns into cycle N+1.
  task automatic start_req(input logic ren, input logic wen, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] wd);
    mem_ren = ren; mem_wen = wen; mem_op = op; addr = a; wdata = wd;
    tick();
    mem_ren = 1'b0; mem_wen = 1'b0; mem_op = 3'b000; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; mem_op = 3'b000; addr = 32'h0; wdata = 32'h0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 32'h0;
    tick(); tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset done/err got=%b/%b exp=0/0", done, err); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset rdata got=%h exp=0", rdata); end
    total++; if ({req_valid, req_wen, req_wmask} !== 6'b0 || req_addr !== 32'h0 || req_wdata !== 32'h0) begin
      bad++; $display("FAIL reset req outputs got valid=%b wen=%b mask=%b addr=%h wdata=%h exp all 0",
                      req_valid, req_wen, req_wmask, req_addr, req_wdata);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_ext();
    req_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      start_req(1'b1, 1'b0, LD_OP[i], LD_ADDR[i], 32'h0);
      total++; if (req_valid !== 1'b1 || req_addr !== LD_WA[i]) begin
        bad++; $display("FAIL load%0d req got valid=%b addr=%h exp 1/%h", i, req_valid, req_addr, LD_WA[i]);
      end
      total++; if (req_wen !== 1'b0 || req_wmask !== 4'b0000) begin
        bad++; $display("FAIL load%0d wen/mask got=%b/%b exp=0/0000", i, req_wen, req_wmask);
      end
      tick();
      total++; if (done !== 1'b0 || req_valid !== 1'b0) begin
        bad++; $display("FAIL load%0d wait got done=%b valid=%b exp 0/0", i, done, req_valid);
      end
      rsp_valid = 1'b1; rsp_rdata = LD_RSP[i];
      tick();
      rsp_valid = 1'b0; rsp_rdata = 32'h0;
      total++; if (done !== 1'b1) begin bad++; $display("FAIL load%0d done at N+3 got=%b exp=1", i, done); end
      total++; if (rdata !== LD_EXP[i]) begin bad++; $display("FAIL load%0d rdata got=%h exp=%h", i, rdata, LD_EXP[i]); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL load%0d err got=%b exp=0", i, err); end
      tick();
      total++; if (done !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL load%0d idle got done=%b busy=%b exp 0/0", i, done, busy);
      end
    end
  endtask

  task automatic test_store_stall();
    req_ready = 1'b0;
    start_req(1'b0, 1'b1, 3'b000, 32'h80000001, 32'h000000AB);
    for (int i = 0; i < 3; i++) begin
      total++; if (req_valid !== 1'b1 || req_addr !== 32'h80000000 || req_wen !== 1'b1) begin
        bad++; $display("FAIL sb stall%0d got valid=%b addr=%h wen=%b exp 1/80000000/1", i, req_valid, req_addr, req_wen);
      end
      total++; if (req_wmask !== 4'b0010 || req_wdata !== 32'hABABABAB) begin
        bad++; $display("FAIL sb stall%0d lanes got mask=%b wdata=%h exp 0010/ababab ab", i, req_wmask, req_wdata);
      end
      total++; if (busy !== 1'b1 || done !== 1'b0) begin
        bad++; $display("FAIL sb stall%0d got busy=%b done=%b exp 1/0", i, busy, done);
      end
      tick();
    end
    req_ready = 1'b1;
    total++; if (req_valid !== 1'b1 || req_wmask !== 4'b0010) begin
      bad++; $display("FAIL sb accept got valid=%b mask=%b exp 1/0010", req_valid, req_wmask);
    end
    tick();
    total++; if (req_valid !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL sb wait got valid=%b done=%b exp 0/0", req_valid, done);
    end
    rsp_valid = 1'b1; rsp_rdata = 32'hFFFFFFFF;
    tick();
    rsp_valid = 1'b0; rsp_rdata = 32'h0;
    total++; if (done !== 1'b1 || err !== 1'b0 || rdata !== 32'h0) begin
      bad++; $display("FAIL sb done got done=%b err=%b rdata=%h exp 1/0/0", done, err, rdata);
    end
    tick();
  endtask

  task automatic test_store_lanes();
    req_ready = 1'b1;
    start_req(1'b0, 1'b1, 3'b001, 32'h80000002, 32'h1234CDEF);
    total++; if (req_wmask !== 4'b1100 || req_wdata !== 32'hCDEFCDEF) begin
      bad++; $display("FAIL sh lanes got mask=%b wdata=%h exp 1100/cdefcdef", req_wmask, req_wdata);
    end
    tick(); rsp_valid = 1'b1; tick(); rsp_valid = 1'b0;
    total++; if (done !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL sh done got done=%b err=%b exp 1/0", done, err); end
    tick();
    start_req(1'b0, 1'b1, 3'b010, 32'h80000008, 32'h1234CDEF);
    total++; if (req_wmask !== 4'b1111 || req_wdata !== 32'h1234CDEF || req_addr !== 32'h80000008) begin
      bad++; $display("FAIL sw lanes got mask=%b wdata=%h addr=%h exp 1111/1234cdef/80000008", req_wmask, req_wdata, req_addr);
    end
    tick(); rsp_valid = 1'b1; tick(); rsp_valid = 1'b0;
    total++; if (done !== 1'b1 || rdata !== 32'h0) begin bad++; $display("FAIL sw done got done=%b rdata=%h exp 1/0", done, rdata); end
    tick();
  endtask

  task automatic test_errors();
    req_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start_req(ER_REN[i], ER_WEN[i], ER_OP[i], ER_ADDR[i], 32'h55555555);
      total++; if (done !== 1'b1 || err !== 1'b1) begin
        bad++; $display("FAIL err%0d at N+1 got done=%b err=%b exp 1/1", i, done, err);
      end
      total++; if (req_valid !== 1'b0 || rdata !== 32'h0) begin
        bad++; $display("FAIL err%0d got valid=%b rdata=%h exp 0/0", i, req_valid, rdata);
      end
      tick();
      total++; if (done !== 1'b0 || busy !== 1'b0 || req_valid !== 1'b0) begin
        bad++; $display("FAIL err%0d after got done=%b busy=%b valid=%b exp 0/0/0", i, done, busy, req_valid);
      end
    end
  endtask

  task automatic test_timeout();
    req_ready = 1'b1;
    start_req(1'b1, 1'b0, 3'b010, 32'h80000000, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      total++; if (done !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL timeout wait%0d got done=%b busy=%b exp 0/1", i, done, busy);
      end
      tick();
    end
    total++; if (done !== 1'b1 || err !== 1'b1 || rdata !== 32'h0) begin
      bad++; $display("FAIL timeout done got done=%b err=%b rdata=%h exp 1/1/0", done, err, rdata);
    end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout idle busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    req_ready = 1'b1;
    start_req(1'b1, 1'b0, 3'b010, 32'h80000000, 32'h0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || req_valid !== 1'b0 || rdata !== 32'h0) begin
      bad++; $display("FAIL midreset got busy=%b done=%b valid=%b rdata=%h exp 0/0/0/0", busy, done, req_valid, rdata);
    end
    rsp_valid = 1'b1; rsp_rdata = 32'h12345678;
    tick();
    rsp_valid = 1'b0; rsp_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      total++; if (done !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0) begin
        bad++; $display("FAIL stray rsp cycle%0d got done=%b busy=%b rdata=%h exp 0/0/0", i, done, busy, rdata);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    // Request held high: ignored in DONE, taken again in the following IDLE cycle.
    mem_ren = 1'b1; mem_wen = 1'b0; mem_op = 3'b010; addr = 32'h80000002;
    tick();
    total++; if (done !== 1'b1 || err !== 1'b1) begin bad++; $display("FAIL b2b first got done=%b err=%b exp 1/1", done, err); end
    tick();
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL b2b idle got done=%b busy=%b exp 0/0", done, busy); end
    mem_op = 3'b000; addr = 32'h80000001;
    tick();
    mem_ren = 1'b0; mem_op = 3'b000; addr = 32'h0;
    total++; if (req_valid !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL b2b second got valid=%b done=%b exp 1/0", req_valid, done);
    end
    tick(); rsp_valid = 1'b1; rsp_rdata = 32'h00007F00; tick(); rsp_valid = 1'b0;
    total++; if (done !== 1'b1 || rdata !== 32'h0000007F) begin
      bad++; $display("FAIL b2b second done got done=%b rdata=%h exp 1/0000007f", done, rdata);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_store_stall();
    test_store_lanes();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_25030081_lsu.md
YSYX_25030081_LSU -- requirements
Module: ysyx_25030081_lsu

Interface
REQ-001 SHALL have parameter: TIMEOUT, 255, max cycles waited in WAIT_RSP before error (1..65535).
REQ-002 SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port: mem_ren  in  1  load request from control unit.
REQ-005 SHALL have port: mem_wen  in  1  store request from control unit.
REQ-006 SHALL have port: mem_op  in  3  access type; [2] unsigned, [1] word, [0] half; 000 byte.
REQ-007 SHALL have port: addr  in  32  byte address from ALU.
REQ-008 SHALL have port: wdata  in  32  store data, rs2, LSB-aligned.
REQ-009 SHALL have ports: rdata  out  32  extended load result; done  out  1  one-cycle completion pulse; err  out  1  error flag, valid with done; busy  out  1  core stall.
REQ-010 SHALL have ports: req_valid  out  1; req_ready  in  1; req_addr  out  32  word-aligned; req_wen  out  1; req_wmask  out  4; req_wdata  out  32  lane-shifted.
REQ-011 SHALL have ports: rsp_valid  in  1  read data or write ack; rsp_rdata  in  32  word data.

Function
REQ-012 SHALL implement FSM states IDLE, REQ, WAIT_RSP, DONE; busy = (state != IDLE).
REQ-013 In IDLE with mem_ren|mem_wen = 1, SHALL register mem_op, addr, wdata, direction; request inputs are ignored in any other state.
REQ-014 Legal ops: load 000,001,010,100,101; store 000,001,010; mem_ren&mem_wen both 1 or any other op is illegal.
REQ-015 Misaligned: half with addr[0]=1, word with addr[1:0]!=0.
REQ-016 Illegal or misaligned request SHALL go IDLE->DONE with err=1, no req_valid issued.
REQ-017 Legal request SHALL go IDLE->REQ; req_valid=1 only in REQ; req_addr={addr[31:2],2'b00}; req_wen = store.
REQ-018 Store mask: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; req_wdata = wdata replicated to lanes (byte x4, half x2); loads drive req_wmask=0.
REQ-019 REQ->WAIT_RSP on req_valid&req_ready same cycle; req_* outputs held stable while req_valid=1 and ready=0.
REQ-020 In WAIT_RSP, rsp_valid=1 SHALL capture rsp_rdata and go DONE with err=0; rsp_valid outside WAIT_RSP is ignored.
REQ-021 WAIT_RSP cycle counter starts at 0 on entry; if it reaches TIMEOUT without rsp_valid, go DONE with err=1, rdata=0.
REQ-022 Load extraction: select byte addr[1:0] or half addr[1]; sign-extend if mem_op[2]=0, zero-extend if 1; word passes through.
REQ-023 done=1 exactly in DONE (one cycle), rdata/err valid only then; DONE->IDLE unconditionally; stores drive rdata=0.
REQ-024 Minimum latency legal access with ready and rsp immediate: request cycle N, done at N+3; error path done at N+1.
REQ-025 New request SHALL be accepted earliest in the IDLE cycle after DONE.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE, counter 0, captured registers 0, and all outputs 0, including mid-transaction; no pending response is remembered.
REQ-027 A rsp_valid arriving after reset release with no outstanding request SHALL be ignored.

Verification
REQ-028 lb addr=0x80000003, rsp_rdata=0x80FF1234 -> req_addr 0x80000000, rdata 0xFFFFFF80, err 0, done at N+3.
REQ-029 lhu addr=0x80000002, rsp_rdata=0x8001ABCD -> rdata 0x00008001; lh same -> 0xFFFF8001.
REQ-030 sb addr=0x80000001 wdata=0x000000AB, req_ready low 3 cycles -> req_wmask 0010, req_wdata 0xABABABAB, req_* stable while stalled, done after ack.
REQ-031 lw addr=0x80000002 -> no req_valid, done at N+1, err 1; mem_op=011 load -> same.
REQ-032 TIMEOUT=4, lw with no rsp_valid -> done with err 1, rdata 0, 4 cycles after WAIT_RSP entry.
REQ-033 rst_n=0 during WAIT_RSP, later stray rsp_valid -> IDLE, busy 0, no done pulse.
